// File: rtl/gray_step_monitor.sv
// rtl/gray_step_monitor.sv - Gray-code step monitor: binary conversion, step/wrap classification, error tracking
module gray_step_monitor #(
    parameter int W      = 4,
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [W-1:0]      gray_in,
    output logic [W-1:0]      bin_out,
    output logic              valid,
    output logic              step,
    output logic              dir,
    output logic              wrap,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              err,
    output logic [ERR_W-1:0]  err_cnt
);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_TRACK = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] bin_new;
    logic [W-1:0] delta;
    logic         cmp;
    logic         is_up, is_down, is_ill;
    logic         clr_act;
    logic         step_d, wrap_d;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin_new = '0;
        for (int i = 0; i < W; i++) begin
            bin_new[i] = ^(gray_in >> i);
        end
    end

    // bin_out doubles as the reference sample for the next comparison.
    assign delta   = bin_new - bin_out;
    assign cmp     = en && (state_q != S_INIT);
    assign is_up   = cmp && (delta == W'(1));
    assign is_down = cmp && (delta == {W{1'b1}});
    assign is_ill  = cmp && !is_up && !is_down && (delta != '0);
    assign clr_act = clr && (state_q != S_INIT);

    always_comb begin
        state_d = state_q;
        step_d  = is_up || is_down;
        wrap_d  = (is_up && (bin_out == {W{1'b1}})) || (is_down && (bin_out == '0));
        case (state_q)
            S_INIT: begin
                if (en) state_d = S_TRACK;
            end
            S_TRACK: begin
                if (is_ill) state_d = S_ERR;
            end
            S_ERR: begin
                if (is_ill)   state_d = S_ERR;
                else if (clr) state_d = S_TRACK;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_INIT;
            bin_out  <= '0;
            valid    <= 1'b0;
            step     <= 1'b0;
            dir      <= 1'b0;
            wrap     <= 1'b0;
            wrap_cnt <= '0;
            err      <= 1'b0;
            err_cnt  <= '0;
        end else begin
            state_q <= state_d;
            step    <= step_d;
            wrap    <= wrap_d;
            if (en) begin
                bin_out <= bin_new;
                valid   <= 1'b1;
                if (is_up)        dir <= 1'b1;
                else if (is_down) dir <= 1'b0;
            end
            // A clear in the same cycle as a wrap still leaves the count at zero.
            if (clr_act)               wrap_cnt <= '0;
            else if (wrap_d && is_up)  wrap_cnt <= wrap_cnt + WRAP_W'(1);
            else if (wrap_d)           wrap_cnt <= wrap_cnt - WRAP_W'(1);
            // An illegal jump beats a simultaneous clear.
            if (is_ill) begin
                err <= 1'b1;
                if (clr_act)                    err_cnt <= ERR_W'(1);
                else if (err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + ERR_W'(1);
            end else if (clr_act) begin
                err     <= 1'b0;
                err_cnt <= '0;
            end
        end
    end

endmodule
